dmem_resp: RTL and testbench

DMEM_RESP -- requirements
Module: dmem_resp

---
 rtl/dmem_resp_if.sv | 23 ++
 rtl/dmem_resp.sv | 92 +++++++++
 tb/tb_dmem_resp.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_resp_if.sv
// rtl/dmem_resp_if.sv - memory-stage data memory request/response bundle
interface dmem_resp_if #(
  parameter int N = 32
);
  logic         req_M;
  logic         we_M;
  logic [N-1:0] addr_M;
  logic [N-1:0] wdata_M;
  logic         stall_M;
  logic         done_M;
  logic [N-1:0] rdata_M;
  logic         err_M;

  modport master (
    output req_M, we_M, addr_M, wdata_M,
    input  stall_M, done_M, rdata_M, err_M
  );

  modport slave (
    input  req_M, we_M, addr_M, wdata_M,
    output stall_M, done_M, rdata_M, err_M
  );
endinterface

// File: rtl/dmem_resp.sv
// rtl/dmem_resp.sv - multi-cycle data memory with wait states (optional DMEM_ALIGN_CHECK_EN)
module dmem_resp #(
  parameter int N     = 32,
  parameter int DEPTH = 256,
  parameter int WAIT  = 2
) (
  input  logic         clk,
  input  logic         rst,
  dmem_resp_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state, state_nxt;
  logic [3:0]   cnt;
  logic         we_q;
  logic [N-1:0] addr_q;
  logic [N-1:0] wdata_q;
  logic [N-1:0] rdata_q;
  logic         err_q;
  logic [N-1:0] mem [DEPTH];

  logic [AW-1:0] word;
  logic          fault;
  logic          accept;
  logic          finish;

  assign word   = addr_q[AW+1:2];
  assign accept = (state == IDLE) && bus.req_M;
  // The access completes at the edge that leaves BUSY with the counter drained.
  assign finish = (state == BUSY) && (cnt == 4'd0);

`ifdef DMEM_ALIGN_CHECK_EN
  assign fault = (|(addr_q >> (AW + 2))) || (|addr_q[1:0]);
`else
  assign fault = |(addr_q >> (AW + 2));
`endif

  // Next-state logic; requests outside IDLE are ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_M) state_nxt = BUSY;
      BUSY:    if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control state, wait counter, load data and fault flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= 4'(WAIT);
      end else if ((state == BUSY) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (finish) begin
        err_q <= fault;
        if (!we_q) rdata_q <= fault ? '0 : mem[word];
      end
    end
  end

  // Request capture; only meaningful once an access is accepted.
  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      we_q    <= bus.we_M;
      addr_q  <= bus.addr_M;
      wdata_q <= bus.wdata_M;
    end
  end

  // Data array is never cleared; a reset edge aborts a pending store.
  always_ff @(posedge clk) begin
    if (!rst && finish && we_q && !fault) mem[word] <= wdata_q;
  end

  assign bus.stall_M = accept || (state == BUSY);
  assign bus.done_M  = (state == DONE);
  assign bus.err_M   = (state == DONE) && err_q;
  assign bus.rdata_M = rdata_q;

endmodule

// File: tb/tb_dmem_resp.sv
// tb/tb_dmem_resp.sv - scoreboard bench for dmem_resp (WAIT=2 and WAIT=0 instances)
module tb_dmem_resp;

  localparam int WAIT0 = 2;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dmem_resp_if #(.N(32)) bus0 ();
  dmem_resp_if #(.N(32)) bus1 ();

  dmem_resp #(.N(32), .DEPTH(256), .WAIT(WAIT0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  dmem_resp #(.N(32), .DEPTH(256), .WAIT(0))     dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  int          nvec = 0;
  int          nerr = 0;
  exp_t        sb[$];
  logic [31:0] model [256];
  logic [31:0] last_rdata = 32'h0;

  function automatic logic tb_fault(input logic [31:0] a);
    logic f;
    f = (a[31:10] != 22'h0);
`ifdef DMEM_ALIGN_CHECK_EN
    if (a[1:0] != 2'b00) f = 1'b1;
`endif
    return f;
  endfunction

  // Full access on bus0: push expectation, drive request, check latency and response.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    exp_t        e;
    exp_t        got;
    logic        flt;
    logic [7:0]  w;
    int          n;
    flt = tb_fault(addr);
    w   = addr[9:2];
    e.err = flt;
    if (we) begin
      e.rdata = last_rdata;
      if (!flt) model[w] = wdata;
    end else begin
      e.rdata    = flt ? 32'h0 : model[w];
      last_rdata = e.rdata;
    end
    sb.push_back(e);
    bus0.req_M   = 1'b1;
    bus0.we_M    = we;
    bus0.addr_M  = addr;
    bus0.wdata_M = wdata;
    #1;
    nvec++;
    if (bus0.stall_M !== 1'b1) begin
      nerr++;
      $display("FAIL stall_on_req addr=%h got=%b exp=1", addr, bus0.stall_M);
    end
    @(posedge clk);
    @(negedge clk);
    bus0.req_M = 1'b0;
    n = 1;
    while (bus0.done_M !== 1'b1 && n < 20) begin
      nvec++;
      if (bus0.stall_M !== 1'b1) begin
        nerr++;
        $display("FAIL stall_busy addr=%h cycle=%0d got=%b exp=1", addr, n, bus0.stall_M);
      end
      @(negedge clk);
      n++;
    end
    nvec++;
    if (n != WAIT0 + 2) begin
      nerr++;
      $display("FAIL done_latency addr=%h got=%0d exp=%0d", addr, n, WAIT0 + 2);
    end
    got.rdata = bus0.rdata_M;
    got.err   = bus0.err_M;
    e = sb.pop_front();
    nvec++;
    if (got.rdata !== e.rdata || got.err !== e.err || bus0.stall_M !== 1'b0) begin
      nerr++;
      $display("FAIL response we=%b addr=%h got rdata=%h err=%b stall=%b exp rdata=%h err=%b stall=0",
               we, addr, got.rdata, got.err, bus0.stall_M, e.rdata, e.err);
    end
    @(negedge clk);
    nvec++;
    if (bus0.done_M !== 1'b0 || bus0.err_M !== 1'b0 || bus0.rdata_M !== e.rdata) begin
      nerr++;
      $display("FAIL after_done addr=%h got done=%b err=%b rdata=%h exp done=0 err=0 rdata=%h",
               addr, bus0.done_M, bus0.err_M, bus0.rdata_M, e.rdata);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus0.req_M = 1'b0; bus0.we_M = 1'b0; bus0.addr_M = '0; bus0.wdata_M = '0;
    bus1.req_M = 1'b0; bus1.we_M = 1'b0; bus1.addr_M = '0; bus1.wdata_M = '0;
    repeat (3) @(negedge clk);
    nvec++;
    if (bus0.stall_M !== 1'b0 || bus0.done_M !== 1'b0 || bus0.err_M !== 1'b0 || bus0.rdata_M !== 32'h0) begin
      nerr++;
      $display("FAIL reset_dut0 got stall=%b done=%b err=%b rdata=%h exp all 0",
               bus0.stall_M, bus0.done_M, bus0.err_M, bus0.rdata_M);
    end
    nvec++;
    if (bus1.stall_M !== 1'b0 || bus1.done_M !== 1'b0 || bus1.err_M !== 1'b0 || bus1.rdata_M !== 32'h0) begin
      nerr++;
      $display("FAIL reset_dut1 got stall=%b done=%b err=%b rdata=%h exp all 0",
               bus1.stall_M, bus1.done_M, bus1.err_M, bus1.rdata_M);
    end
    rst = 1'b0;
    last_rdata = 32'h0;
    @(negedge clk);
  endtask

  task automatic test_store_load();
    access(1'b1, 32'h10, 32'hDEADBEEF);
    access(1'b0, 32'h10, 32'h0);
  endtask

  task automatic test_out_of_range();
    access(1'b1, 32'h0, 32'h0BADF00D);
    access(1'b0, 32'h400, 32'h0);
    access(1'b1, 32'h400, 32'hFFFF0000);
    access(1'b0, 32'h0, 32'h0);
    access(1'b0, 32'h8000_0010, 32'h0);
  endtask

  task automatic test_reset_in_busy();
    access(1'b1, 32'h20, 32'hA5A50001);
    access(1'b0, 32'h20, 32'h0);
    bus0.req_M = 1'b1; bus0.we_M = 1'b1; bus0.addr_M = 32'h20; bus0.wdata_M = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    bus0.req_M = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    nvec++;
    if (bus0.stall_M !== 1'b0 || bus0.done_M !== 1'b0 || bus0.err_M !== 1'b0 || bus0.rdata_M !== 32'h0) begin
      nerr++;
      $display("FAIL reset_in_busy got stall=%b done=%b err=%b rdata=%h exp all 0",
               bus0.stall_M, bus0.done_M, bus0.err_M, bus0.rdata_M);
    end
    rst = 1'b0;
    last_rdata = 32'h0;
    @(negedge clk);
    access(1'b0, 32'h20, 32'h0);
  endtask

  task automatic test_misalign();
    access(1'b1, 32'h10, 32'hCAFEF00D);
    access(1'b0, 32'h13, 32'h0);
    access(1'b1, 32'h13, 32'h11112222);
    access(1'b0, 32'h10, 32'h0);
  endtask

  task automatic test_patterns();
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      access(1'b1, 32'(i * 4 + 8'h80), d);
      access(1'b0, 32'(i * 4 + 8'h80), 32'h0);
    end
    access(1'b0, 32'h3FC, 32'h0);
  endtask

  // WAIT=0 instance with the request held high: one DONE every three cycles.
  task automatic test_back_to_back();
    int dones;
    logic exp_done;
    dones = 0;
    bus1.req_M = 1'b1; bus1.we_M = 1'b1; bus1.addr_M = 32'h40; bus1.wdata_M = 32'h77;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      exp_done = (i % 3 == 1);
      if (bus1.done_M === 1'b1) dones++;
      nvec++;
      if (bus1.done_M !== exp_done || bus1.stall_M !== !exp_done) begin
        nerr++;
        $display("FAIL b2b_cycle%0d got done=%b stall=%b exp done=%b stall=%b",
                 i, bus1.done_M, bus1.stall_M, exp_done, !exp_done);
      end
    end
    bus1.req_M = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus1.done_M === 1'b1) dones++;
    end
    nvec++;
    if (dones != 3) begin
      nerr++;
      $display("FAIL b2b_done_count got=%0d exp=3", dones);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_out_of_range();
    test_reset_in_busy();
    test_misalign();
    test_patterns();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
